// File: rtl/ifu_pkg.sv
// Shared types and constants for the fetch-stage PC unit and its in-flight queue.
package ifu_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_INC  = 4;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
    logic               pred_taken;
    logic [ADDR_W-1:0]  pred_target;
    logic               filled;
  } fetch_entry_t;

  // Fresh entry at request time; the instruction arrives later with the response.
  function automatic fetch_entry_t new_entry(input logic [ADDR_W-1:0] pc,
                                             input logic              pred_taken,
                                             input logic [ADDR_W-1:0] pred_target);
    fetch_entry_t e;
    e.pc          = pc;
    e.instr       = '0;
    e.pred_taken  = pred_taken;
    e.pred_target = pred_target;
    e.filled      = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of in-flight fetches: alloc (tail), fill and pop (head) pointers,
// each carrying an extra wrap bit so full/empty and the unfilled count fall out of subtraction.
module fetch_queue
  import ifu_pkg::*;
#(
  parameter int unsigned Q_DEPTH    = 4,
  parameter int unsigned Q_PTR_BITS = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                push,
  input  fetch_entry_t        push_entry,
  input  logic                fill,
  input  logic [INSTR_W-1:0]  fill_data,
  input  logic                pop,
  output fetch_entry_t        head_entry,
  output logic                head_valid,
  output logic [Q_PTR_BITS:0] count,
  output logic [Q_PTR_BITS:0] unfilled
);

  logic [Q_PTR_BITS:0] head_q;
  logic [Q_PTR_BITS:0] tail_q;
  logic [Q_PTR_BITS:0] fill_q;
  fetch_entry_t        mem_q [Q_DEPTH];
  logic                fill_en;
  logic                pop_en;

  assign count      = tail_q - head_q;
  assign unfilled   = tail_q - fill_q;
  assign head_entry = mem_q[head_q[Q_PTR_BITS-1:0]];
  assign head_valid = (count != '0) && head_entry.filled;

  // A response with no unfilled entry has nowhere to go and is ignored.
  assign fill_en = fill && (unfilled != '0);
  assign pop_en  = pop && head_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      for (int unsigned i = 0; i < Q_DEPTH; i++) begin
        mem_q[i].filled <= 1'b0;
      end
    end else if (flush) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
    end else begin
      if (push) begin
        mem_q[tail_q[Q_PTR_BITS-1:0]] <= push_entry;
        tail_q                        <= tail_q + 1'b1;
      end
      // fill_q always trails tail_q here, so fill and push never hit the same slot.
      if (fill_en) begin
        mem_q[fill_q[Q_PTR_BITS-1:0]].instr  <= fill_data;
        mem_q[fill_q[Q_PTR_BITS-1:0]].filled <= 1'b1;
        fill_q                               <= fill_q + 1'b1;
      end
      if (pop_en) begin
        head_q <= head_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator: next-PC selection from the BPU, imem request gating, in-flight
// tracking and discarding of stale responses after an execute redirect.
module fetch_pc_unit
  import ifu_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH  = ADDR_W,
  parameter int unsigned           INSTR_WIDTH = INSTR_W,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned           Q_DEPTH     = 4,
  parameter int unsigned           Q_PTR_BITS  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [ADDR_WIDTH-1:0]  fetch_pc,
  input  logic                   predict_taken,
  input  logic [ADDR_WIDTH-1:0]  predict_target,
  input  logic                   prediction_valid,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  input  logic                   imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rsp_data,
  output logic                   if_valid,
  input  logic                   if_ready,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [ADDR_WIDTH-1:0]  if_pc,
  output logic                   if_pred_taken,
  output logic [ADDR_WIDTH-1:0]  if_pred_target,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc
);

  localparam logic [Q_PTR_BITS+1:0] DepthLim = (Q_PTR_BITS + 2)'(Q_DEPTH);

  logic [ADDR_WIDTH-1:0] fetch_pc_q;
  logic [ADDR_WIDTH-1:0] fetch_pc_d;
  logic [Q_PTR_BITS:0]   drop_cnt_q;
  logic [Q_PTR_BITS:0]   drop_cnt_d;
  logic [Q_PTR_BITS:0]   q_count;
  logic [Q_PTR_BITS:0]   q_unfilled;
  logic [Q_PTR_BITS+1:0] in_flight;
  logic                  req_fire;
  logic                  rsp_drop;
  logic                  rsp_consumed;
  logic                  q_fill;
  logic                  q_pop;
  logic                  head_valid;
  fetch_entry_t          head_entry;
  fetch_entry_t          push_entry;

  // Only prediction_valid (BTB hit and taken) steers fetch; a bare taken bit is ignored.
  logic unused_predict_taken;
  assign unused_predict_taken = predict_taken;

  assign fetch_pc  = fetch_pc_q;
  assign in_flight = {1'b0, q_count} + {1'b0, drop_cnt_q};

  assign imem_req_valid = !reset && !redirect_valid && (in_flight < DepthLim);
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop     = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_consumed = rsp_drop || (imem_rsp_valid && (q_unfilled != '0));
  assign q_fill       = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;
  assign q_pop        = head_valid && if_ready && !redirect_valid;

  assign push_entry = new_entry(fetch_pc_q, prediction_valid, predict_target);

  fetch_queue #(
    .Q_DEPTH    (Q_DEPTH),
    .Q_PTR_BITS (Q_PTR_BITS)
  ) u_queue (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (req_fire),
    .push_entry (push_entry),
    .fill       (q_fill),
    .fill_data  (imem_rsp_data),
    .pop        (q_pop),
    .head_entry (head_entry),
    .head_valid (head_valid),
    .count      (q_count),
    .unfilled   (q_unfilled)
  );

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (req_fire) begin
      fetch_pc_d = prediction_valid ? predict_target : fetch_pc_q + ADDR_WIDTH'(PC_INC);
    end
  end

  // On redirect every still-unfilled request becomes a response to throw away;
  // a response landing in the redirect cycle itself already accounts for one of them.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      drop_cnt_d = drop_cnt_q + q_unfilled - (Q_PTR_BITS + 1)'(rsp_consumed);
    end else if (rsp_drop) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign if_valid       = head_valid;
  assign if_instr       = head_entry.instr;
  assign if_pc          = head_entry.pc;
  assign if_pred_taken  = head_entry.pred_taken;
  assign if_pred_target = head_entry.pred_target;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: an imem/BPU model drives the DUT, expected decode
// entries are queued per phase and a negedge monitor compares whatever decode receives.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_pc;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        prediction_valid;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [31:0] if_pred_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .clk              (clk),
    .reset            (reset),
    .fetch_pc         (fetch_pc),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .prediction_valid (prediction_valid),
    .imem_req_valid   (imem_req_valid),
    .imem_req_ready   (imem_req_ready),
    .imem_rsp_valid   (imem_rsp_valid),
    .imem_rsp_data    (imem_rsp_data),
    .if_valid         (if_valid),
    .if_ready         (if_ready),
    .if_instr         (if_instr),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_target   (if_pred_target),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        pt;
    logic [31:0] tgt;
  } exp_t;

  localparam logic [31:0] BpuPc  = 32'h8;
  localparam logic [31:0] BpuTgt = 32'h100;

  exp_t        exp_q[$];
  logic [31:0] pend_q[$];
  exp_t        mon_e;
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          budget = 0;
  int          fires  = 0;
  logic        rsp_en = 1'b0;
  logic        bpu_en = 1'b0;

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic expect_pc(input logic [31:0] pc, input logic pt, input logic [31:0] tgt);
    exp_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    e.pt    = pt;
    e.tgt   = tgt;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  // Advance one cycle and drive imem response / BPU / ready just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (rsp_en && pend_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    imem_req_ready   = (budget > 0);
    predict_taken    = bpu_en;
    prediction_valid = bpu_en && (fetch_pc == BpuPc);
    predict_target   = bpu_en ? BpuTgt : 32'h0;
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() > 0; i++) tick();
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic redirect_to(input logic [31:0] pc, input int new_budget);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    budget         = new_budget;
    fires          = 0;
  endtask

  // imem request capture and decode-side scoreboard monitor.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req_valid && imem_req_ready) begin
        pend_q.push_back(fetch_pc);
        fires++;
        budget--;
      end
      if (if_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_if: got pc=%h instr=%h want nothing", if_pc, if_instr);
        end else begin
          mon_e = exp_q[0];
          if (if_pc !== mon_e.pc || if_instr !== mon_e.instr ||
              if_pred_taken !== mon_e.pt || if_pred_target !== mon_e.tgt) begin
            n_err++;
            $display("FAIL if_entry: got pc=%h instr=%h pt=%0d tgt=%h want pc=%h instr=%h pt=%0d tgt=%h",
                     if_pc, if_instr, if_pred_taken, if_pred_target,
                     mon_e.pc, mon_e.instr, mon_e.pt, mon_e.tgt);
          end
          if (if_ready && !redirect_valid) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset            = 1'b1;
    if_ready         = 1'b1;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    imem_req_ready   = 1'b0;
    imem_rsp_valid   = 1'b0;
    imem_rsp_data    = '0;
    predict_taken    = 1'b0;
    prediction_valid = 1'b0;
    predict_target   = '0;

    // Reset, then plain sequential fetch.
    budget = 4;
    rsp_en = 1'b1;
    for (int i = 0; i < 4; i++) expect_pc(32'(i * 4), 1'b0, 32'h0);
    repeat (3) tick();
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    reset = 1'b0;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_pc", fetch_pc, 32'h0);
    wait_drain("seq_drain", 40);

    // Predicted taken at 0x8 -> 0x100; predict_taken alone is asserted everywhere.
    tick();
    redirect_to(32'h0, 5);
    bpu_en = 1'b1;
    expect_pc(32'h0, 1'b0, BpuTgt);
    expect_pc(32'h4, 1'b0, BpuTgt);
    expect_pc(32'h8, 1'b1, BpuTgt);
    expect_pc(32'h100, 1'b0, BpuTgt);
    expect_pc(32'h104, 1'b0, BpuTgt);
    wait_drain("pred_drain", 40);
    bpu_en = 1'b0;

    // Decode backpressure: the queue fills to depth and requests stop.
    tick();
    if_ready = 1'b0;
    redirect_to(32'h300, 6);
    for (int i = 0; i < 6; i++) expect_pc(32'h300 + 32'(i * 4), 1'b0, 32'h0);
    repeat (10) tick();
    check("bp_fires", 32'(fires), 32'd4);
    check("bp_req_valid", 32'(imem_req_valid), 32'd0);
    if_ready = 1'b1;
    wait_drain("bp_drain", 40);

    // Flush with three requests in flight and no responses yet.
    tick();
    rsp_en = 1'b0;
    redirect_to(32'h400, 3);
    for (int i = 0; i < 20 && fires < 3; i++) tick();
    check("fl_old_fires", 32'(fires), 32'd3);
    expect_pc(32'h200, 1'b0, 32'h0);
    expect_pc(32'h204, 1'b0, 32'h0);
    expect_pc(32'h208, 1'b0, 32'h0);
    tick();
    redirect_to(32'h200, 3);
    tick();
    check("fl_drop_cnt", 32'(dut.drop_cnt_q), 32'd3);
    repeat (6) tick();
    check("fl_new_fires", 32'(fires), 32'd1);
    check("fl_req_valid", 32'(imem_req_valid), 32'd0);
    rsp_en = 1'b1;
    wait_drain("fl_drain", 40);

    // Redirect in the same cycle as a response for the old path.
    tick();
    rsp_en = 1'b0;
    redirect_to(32'h500, 2);
    for (int i = 0; i < 20 && fires < 2; i++) tick();
    check("co_old_fires", 32'(fires), 32'd2);
    expect_pc(32'h600, 1'b0, 32'h0);
    expect_pc(32'h604, 1'b0, 32'h0);
    rsp_en = 1'b1;
    tick();
    redirect_to(32'h600, 2);
    tick();
    check("co_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    wait_drain("co_drain", 40);

    repeat (3) tick();
    check("end_pend_empty", 32'(pend_q.size()), 32'd0);
    check("end_if_valid", 32'(if_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
